// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one full-adder cell sequenced LSB first over WIDTH cycles
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] opa, opb, res;
  logic [CW-1:0] cnt;
  logic cr, fa_sum, fa_carry, last;
  always_comb begin
    fa_sum = opa[0] ^ opb[0] ^ cr;
    fa_carry = (opa[0] & opb[0]) | (cr & (opa[0] ^ opb[0]));
    last = cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
          state == RUN  ? (last ? DONE : RUN) :
                          (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready = state == IDLE;
    busy = state != IDLE;
    out_valid = state == DONE;
  end
  // sum/cout/ovf load only on the last bit so partial results never show
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      opa <= '0;
      opb <= '0;
      res <= '0;
      cr <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      opa <= a;
      opb <= b;
      cr <= cin;
      cnt <= '0;
    end else if (state == RUN) begin
      opa <= opa >> 1;
      opb <= opb >> 1;
      res <= {fa_sum, res[WIDTH-1:1]};
      cr <= fa_carry;
      cnt <= last ? '0 : cnt + CW'(1);
      if (last) begin
        sum <= {fa_sum, res[WIDTH-1:1]};
        cout <= fa_carry;
        ovf <= cr ^ fa_carry;
      end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks of serial_adder_ctrl against an arithmetic model
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic clk = 0, rst_n = 1, in_valid = 0, cin = 0, out_ready = 1;
  logic in_ready, out_valid, cout, ovf, busy;
  logic [W-1:0] a = '0, b = '0, sum;
  int checks = 0, errors = 0, n_dut = 0, n_mod = 0, m_wait = 0;
  logic m_done = 0, m_idle, go = 0;
  logic [W+1:0] pend = '0, expv = '0;
  always #5 clk = ~clk;
  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask
  // {ovf, cout, sum} from plain arithmetic and the sign rule
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return {(x[W-1] == y[W-1]) && (s[W-1] != x[W-1]), s};
  endfunction
  assign m_idle = !m_done && m_wait == 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_wait <= 0;
      m_done <= 1'b0;
      expv <= '0;
    end else if (m_done) begin
      if (out_ready) begin
        m_done <= 1'b0;
        n_mod <= n_mod + 1;
      end
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_done <= 1'b1;
        expv <= pend;
      end
    end else if (in_valid) begin
      m_wait <= W;
      pend <= ref_add(a, b, cin);
    end
  always @(negedge clk)
    if (go) begin
      chk("out_valid", out_valid, m_done);
      chk("in_ready", in_ready, m_idle);
      chk("busy", busy, !m_idle);
      chk("result", {ovf, cout, sum}, expv);
      if (out_valid && out_ready) n_dut++;
    end
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                    input logic [W+1:0] lit, input int stall, input bit tog);
    int t;
    a = x; b = y; cin = c; in_valid = 1; out_ready = stall == 0;
    @(posedge clk); #1;
    in_valid = 0;
    t = 0;
    while (!out_valid && t < 3 * W) begin
      if (tog) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = ~in_valid;
      end
      @(posedge clk); #1;
      t++;
    end
    in_valid = 0;
    chk("latency", t, W);
    chk("dut_vs_lit", {ovf, cout, sum}, lit);
    chk("model_vs_lit", expv, lit);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("held_valid", out_valid, 1);
      chk("held_result", {ovf, cout, sum}, lit);
      chk("held_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
  endtask
  initial begin
    int n, g;
    bit acc;
    #2 rst_n = 0;
    #1 go = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf, out_valid, busy, in_ready}, 5'b00001);
    rst_n = 1;
    op(8'h0F, 8'h01, 1'b0, 10'h010, 0, 0);
    op(8'hFF, 8'h01, 1'b0, 10'h100, 0, 0);
    op(8'h7F, 8'h00, 1'b1, 10'h280, 0, 0);
    op(8'h80, 8'h80, 1'b0, 10'h300, 0, 1);
    op(8'hC3, 8'h5A, 1'b1, 10'h11E, 5, 0);
    a = 8'h55; b = 8'h33; cin = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (4) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("midrst_sum", sum, 0);
    chk("midrst_flags", {cout, ovf, out_valid, busy, in_ready}, 5'b00001);
    @(posedge clk); #1;
    rst_n = 1;
    op(8'h01, 8'h02, 1'b0, 10'h003, 0, 0);
    n = 0; g = 0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1;
    while (n < 1000 && g < 60000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      out_ready = $urandom_range(0, 3) != 0;
      if (acc) begin
        n++;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        in_valid = $urandom_range(0, 3) != 0;
      end else if (!in_valid) in_valid = 1'($urandom_range(0, 1));
      g++;
    end
    in_valid = 0;
    out_ready = 1;
    chk("random_accepts", n, 1000);
    g = 0;
    while (busy && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain", g < 40, 1);
    @(negedge clk); #1;
    chk("result_count", n_dut, n_mod);
    chk("model_count", n_mod, 1006);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
